ps2_keypad_mapper: RTL and testbench
====================================

// Module: ps2_keypad_mapper
// PURPOSE
//  Converts MiSTer-style ps2_key events into the 32-bit joystick word the emu control stage consumes.
//  Tracks per-key press/release state, registers it and ORs it with the native joystick word.
//  Sits directly upstream of the keypad/ctrl multiplexing; joystick_o drives joystick_0.
// PARAMETERS
//  TURBO_HALF  20'd357955  clk_sys cycles per turbo half-period (~30 Hz at 21.477 MHz); PS2_TURBO_EN only
// PORTS
//  clk_sys     in   1   system clock, the only clock
//  reset_n     in   1   asynchronous, active-low reset
//  ps2_key     in   11  [10] toggles per event, [9] pressed, [8] extended (E0), [7:0] scancode
//  clear_i     in   1   synchronous release-all (focus loss, menu open)
//  joy_i       in   32  native joystick word, merged by OR
//  joystick_o  out  32  registered merged word: [0]R [1]L [2]D [3]U [4]fire1 [5]fire2 [6]* [7]# [17:8]digits 0-9 [18]purple [19]blue; [31:20]=0
//  event_o     out  1   one-cycle pulse when a mapped key changes state
// BEHAVIOUR
//  Reset: joystick_o=0, event_o=0, key state=0, armed=0, toggle_q=0, turbo counter=0, turbo phase=0.
//  Arming: first cycle after reset release loads toggle_q<=ps2_key[10] and sets armed=1; no event is taken that cycle.
//  Stage 1 (capture): armed & (ps2_key[10]!=toggle_q) -> latch {ext,pressed,code}, set valid, toggle_q<=ps2_key[10].
//  Stage 2 (lookup+update): LUT maps {ext,code} to a one-hot bit index or to none.
//   Mapped: key_state[idx]<=pressed; event_o=1 only if the bit changes.
//   Unmapped: no state change, no event_o.
//  Stage 3: joystick_o<=key_state|joy_i (with turbo masking when enabled).
//  Latency: key toggle edge to joystick_o is 3 clk_sys; joy_i to joystick_o is 1 clk_sys.
//  Extended must match exactly: E0+75=Up, E0+72=Down, E0+6B=Left, E0+74=Right. Plain 75/72/6B/74 are unmapped.
//  Plain codes: 14=fire1 (LCtrl), 11=fire2 (LAlt), 45/16/1E/26/25/2E/36/3D/3E/46=digits 0..9.
//  Plain codes: 7C=*, 55=#, 15=purple (Q), 1D=blue (W).
//  Repeated press of a held key: idempotent, no event_o. Release of a not-held key: idempotent.
//  Two toggles on consecutive cycles: both are processed; the pipeline accepts one event per cycle.
//  clear_i: key_state<=0 next cycle. clear_i and a stage-2 event in the same cycle: clear wins, event discarded, event_o=0.
//  Reset asserted mid-operation: all state returns to reset values immediately; the in-flight event is lost.
//  Opposing directions (U+D or L+R) pass through unfiltered; the downstream stage resolves them.
// CONFIGURATION
//  PS2_TURBO_EN defined:
//   While key_state[fire2] is set, the counter runs 0..TURBO_HALF-1 and the turbo phase toggles at each wrap.
//   joystick_o[5] = (key_state[5] & phase) | joy_i[5].
//   When fire2 is released, or clear_i is asserted, the counter and phase reset to 0.
//   The first press therefore shows fire2 low for TURBO_HALF cycles, then square-waves.
//  PS2_TURBO_EN not defined: fire2 is a plain held bit; counter logic is absent and TURBO_HALF is ignored.
// STRUCTURE
//  Package ps2_keypad_pkg holds:
//   localparams for joystick bit indices (JOY_RIGHT..JOY_BLUE).
//   localparams for scancodes (SC_UP..SC_BLUE).
//   typedef ps2_evt_t {ext, pressed, code[7:0]}.
//  Sub-module ps2_scancode_lut: combinational; ext,code -> hit (1) + idx (5). Instanced once in stage 2.
// TESTING
//  1 Reset released with ps2_key[10]=1 held -> no event_o, joystick_o stays 32'h0 (arming works).
//  2 Toggle with {ext=1,pressed=1,75} -> 3 cycles later joystick_o=32'h8, event_o pulses once.
//    Same key with pressed=0 -> joystick_o=0.
//  3 Toggle {ext=0,pressed=1,75} -> joystick_o unchanged, event_o=0 (extended mismatch).
//  4 Press 16 then 45 on back-to-back cycles -> joystick_o=32'h300. clear_i -> 32'h0 next cycle.
//  5 joy_i=32'h10 while digit 5 (2E) held -> joystick_o=32'h2010. Second 2E press -> event_o=0.
//  6 PS2_TURBO_EN with TURBO_HALF=4: hold 11 -> bit5 sequence 0000 1111 0000. Release -> bit5=0, counter=0.

Source files
------------

// File: rtl/ps2_keypad_pkg.sv
// Shared joystick bit positions, PS/2 scancodes and the captured-event type
// used by the keypad mapper and its scancode lookup.
package ps2_keypad_pkg;

    localparam int unsigned NUM_KEYS = 20;

    localparam logic [4:0] JOY_RIGHT  = 5'd0;
    localparam logic [4:0] JOY_LEFT   = 5'd1;
    localparam logic [4:0] JOY_DOWN   = 5'd2;
    localparam logic [4:0] JOY_UP     = 5'd3;
    localparam logic [4:0] JOY_FIRE1  = 5'd4;
    localparam logic [4:0] JOY_FIRE2  = 5'd5;
    localparam logic [4:0] JOY_STAR   = 5'd6;
    localparam logic [4:0] JOY_HASH   = 5'd7;
    localparam logic [4:0] JOY_DIG0   = 5'd8;
    localparam logic [4:0] JOY_PURPLE = 5'd18;
    localparam logic [4:0] JOY_BLUE   = 5'd19;

    // Direction codes are only valid with the E0 prefix
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_FIRE1  = 8'h14;
    localparam logic [7:0] SC_FIRE2  = 8'h11;
    localparam logic [7:0] SC_DIG0   = 8'h45;
    localparam logic [7:0] SC_DIG1   = 8'h16;
    localparam logic [7:0] SC_DIG2   = 8'h1E;
    localparam logic [7:0] SC_DIG3   = 8'h26;
    localparam logic [7:0] SC_DIG4   = 8'h25;
    localparam logic [7:0] SC_DIG5   = 8'h2E;
    localparam logic [7:0] SC_DIG6   = 8'h36;
    localparam logic [7:0] SC_DIG7   = 8'h3D;
    localparam logic [7:0] SC_DIG8   = 8'h3E;
    localparam logic [7:0] SC_DIG9   = 8'h46;
    localparam logic [7:0] SC_STAR   = 8'h7C;
    localparam logic [7:0] SC_HASH   = 8'h55;
    localparam logic [7:0] SC_PURPLE = 8'h15;
    localparam logic [7:0] SC_BLUE   = 8'h1D;

    typedef struct packed {
        logic       ext;
        logic       pressed;
        logic [7:0] code;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_scancode_lut.sv
// Combinational scancode decoder: {ext, code} -> joystick bit index, or no hit.
module ps2_scancode_lut
    import ps2_keypad_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output logic       hit,
    output logic [4:0] idx
);

    always_comb begin
        hit = 1'b1;
        idx = '0;
        if (ext) begin
            case (code)
                SC_UP:    idx = JOY_UP;
                SC_DOWN:  idx = JOY_DOWN;
                SC_LEFT:  idx = JOY_LEFT;
                SC_RIGHT: idx = JOY_RIGHT;
                default:  hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_FIRE1:  idx = JOY_FIRE1;
                SC_FIRE2:  idx = JOY_FIRE2;
                SC_STAR:   idx = JOY_STAR;
                SC_HASH:   idx = JOY_HASH;
                SC_DIG0:   idx = JOY_DIG0;
                SC_DIG1:   idx = JOY_DIG0 + 5'd1;
                SC_DIG2:   idx = JOY_DIG0 + 5'd2;
                SC_DIG3:   idx = JOY_DIG0 + 5'd3;
                SC_DIG4:   idx = JOY_DIG0 + 5'd4;
                SC_DIG5:   idx = JOY_DIG0 + 5'd5;
                SC_DIG6:   idx = JOY_DIG0 + 5'd6;
                SC_DIG7:   idx = JOY_DIG0 + 5'd7;
                SC_DIG8:   idx = JOY_DIG0 + 5'd8;
                SC_DIG9:   idx = JOY_DIG0 + 5'd9;
                SC_PURPLE: idx = JOY_PURPLE;
                SC_BLUE:   idx = JOY_BLUE;
                default:   hit = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keypad_mapper.sv
// Three-stage PS/2 key-event to joystick-word mapper, merged with the native joystick.
// Define PS2_TURBO_EN to square-wave fire2 at TURBO_HALF cycles per half-period.
module ps2_keypad_mapper
    import ps2_keypad_pkg::*;
#(
    parameter logic [19:0] TURBO_HALF = 20'd357955
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        clear_i,
    input  logic [31:0] joy_i,
    output logic [31:0] joystick_o,
    output logic        event_o
);

    logic                armed_reg;
    logic                toggle_reg;
    logic                valid_reg;
    ps2_evt_t            evt_reg;
    logic [NUM_KEYS-1:0] key_state_reg, key_state_next;
    logic                event_reg, event_next;
    logic [31:0]         joystick_reg, joystick_next;
    logic                lut_hit;
    logic [4:0]          lut_idx;
    logic                turbo_phase;

    // Stage 1: the first cycle out of reset only samples the toggle bit
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            armed_reg  <= 1'b0;
            toggle_reg <= 1'b0;
            valid_reg  <= 1'b0;
            evt_reg    <= '0;
        end else begin
            armed_reg <= 1'b1;
            valid_reg <= 1'b0;
            if (!armed_reg) begin
                toggle_reg <= ps2_key[10];
            end else if (ps2_key[10] != toggle_reg) begin
                toggle_reg <= ps2_key[10];
                valid_reg  <= 1'b1;
                evt_reg    <= '{ext: ps2_key[8], pressed: ps2_key[9], code: ps2_key[7:0]};
            end
        end
    end

    ps2_scancode_lut u_lut (
        .ext  (evt_reg.ext),
        .code (evt_reg.code),
        .hit  (lut_hit),
        .idx  (lut_idx)
    );

    // Stage 2: clear overrides any event arriving in the same cycle
    always_comb begin
        key_state_next = key_state_reg;
        event_next     = 1'b0;
        if (clear_i) begin
            key_state_next = '0;
        end else if (valid_reg && lut_hit) begin
            key_state_next[lut_idx] = evt_reg.pressed;
            event_next              = (key_state_reg[lut_idx] != evt_reg.pressed);
        end
    end

`ifdef PS2_TURBO_EN
    logic [19:0] turbo_cnt_reg;
    logic        turbo_phase_reg;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            turbo_cnt_reg   <= '0;
            turbo_phase_reg <= 1'b0;
        end else if (clear_i || !key_state_reg[JOY_FIRE2]) begin
            turbo_cnt_reg   <= '0;
            turbo_phase_reg <= 1'b0;
        end else if (turbo_cnt_reg == TURBO_HALF - 20'd1) begin
            turbo_cnt_reg   <= '0;
            turbo_phase_reg <= ~turbo_phase_reg;
        end else begin
            turbo_cnt_reg <= turbo_cnt_reg + 20'd1;
        end
    end

    assign turbo_phase = turbo_phase_reg;
`else
    logic turbo_unused;
    assign turbo_unused = ^TURBO_HALF;
    assign turbo_phase  = 1'b1;
`endif

    // Stage 3: per-bit merge; fire2 is gated by the turbo phase (constant 1 without turbo)
    for (genvar gi = 0; gi < 32; gi++) begin : g_merge
        if (gi == int'(JOY_FIRE2)) begin : g_fire2
            assign joystick_next[gi] = (key_state_reg[gi] & turbo_phase) | joy_i[gi];
        end else if (gi < int'(NUM_KEYS)) begin : g_key
            assign joystick_next[gi] = key_state_reg[gi] | joy_i[gi];
        end else begin : g_pass
            assign joystick_next[gi] = joy_i[gi];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            key_state_reg <= '0;
            event_reg     <= 1'b0;
            joystick_reg  <= '0;
        end else begin
            key_state_reg <= key_state_next;
            event_reg     <= event_next;
            joystick_reg  <= joystick_next;
        end
    end

    assign joystick_o = joystick_reg;
    assign event_o    = event_reg;

endmodule

// File: tb/tb_ps2_keypad_mapper.sv
// Directed-vector bench for ps2_keypad_mapper; turbo sequence exercised when PS2_TURBO_EN is defined.
module tb_ps2_keypad_mapper;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = 11'h400;
    logic        clear_i = 1'b0;
    logic [31:0] joy_i   = '0;
    logic [31:0] joystick_o;
    logic        event_o;

    int err_cnt = 0;
    int chk_cnt = 0;

    ps2_keypad_mapper #(.TURBO_HALF(20'd4)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .clear_i    (clear_i),
        .joy_i      (joy_i),
        .joystick_o (joystick_o),
        .event_o    (event_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    // Drive a new event by flipping the toggle bit (call right after a negedge)
    task automatic drive_key(input logic ext, input logic pressed, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    // One event, then watch event_o over three cycles (expect a pulse only in the
    // second) and joystick_o after the third edge.
    task automatic send_key(input string tag, input logic ext, input logic pressed,
                            input logic [7:0] code, input logic exp_evt, input logic [31:0] exp_joy);
        logic [2:0] ev;
        drive_key(ext, pressed, code);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_sys);
            ev[2-i] = event_o;
        end
        check_val({tag, "_evt"}, {29'd0, ev}, {30'd0, exp_evt, 1'b0});
        check_val({tag, "_joy"}, joystick_o, exp_joy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_sys);
    endtask

    initial begin
        logic [3:0] ev_seq;

        // Reset with the toggle bit already high
        idle(2);
        check_val("rst_joy", joystick_o, 32'h0);
        check_val("rst_evt", {31'd0, event_o}, 32'h0);
        reset_n = 1'b1;
        ev_seq = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sys);
            ev_seq[i] = event_o;
        end
        check_val("arm_evt", {28'd0, ev_seq}, 32'h0);
        check_val("arm_joy", joystick_o, 32'h0);

        send_key("up_press",    1'b1, 1'b1, 8'h75, 1'b1, 32'h0000_0008);
        send_key("up_release",  1'b1, 1'b0, 8'h75, 1'b1, 32'h0000_0000);
        send_key("plain75",     1'b0, 1'b1, 8'h75, 1'b0, 32'h0000_0000);
        send_key("ext_14",      1'b1, 1'b1, 8'h14, 1'b0, 32'h0000_0000);
        send_key("down_press",  1'b1, 1'b1, 8'h72, 1'b1, 32'h0000_0004);
        send_key("upd_press",   1'b1, 1'b1, 8'h75, 1'b1, 32'h0000_000C);
        send_key("left_press",  1'b1, 1'b1, 8'h6B, 1'b1, 32'h0000_000E);
        send_key("right_press", 1'b1, 1'b1, 8'h74, 1'b1, 32'h0000_000F);
        send_key("fire1",       1'b0, 1'b1, 8'h14, 1'b1, 32'h0000_001F);
        send_key("star",        1'b0, 1'b1, 8'h7C, 1'b1, 32'h0000_005F);
        send_key("hash",        1'b0, 1'b1, 8'h55, 1'b1, 32'h0000_00DF);
        send_key("purple",      1'b0, 1'b1, 8'h15, 1'b1, 32'h0004_00DF);
        send_key("blue",        1'b0, 1'b1, 8'h1D, 1'b1, 32'h000C_00DF);
        send_key("dig9",        1'b0, 1'b1, 8'h46, 1'b1, 32'h000E_00DF);
`ifndef PS2_TURBO_EN
        send_key("fire2",       1'b0, 1'b1, 8'h11, 1'b1, 32'h000E_00FF);
`endif

        // Clear: key state drops on the next edge, joystick one edge later
        clear_i = 1'b1;
        @(negedge clk_sys);
        clear_i = 1'b0;
        @(negedge clk_sys);
        check_val("clear_all", joystick_o, 32'h0);

        // Back-to-back toggles: digit1 then digit0
        drive_key(1'b0, 1'b1, 8'h16);
        @(negedge clk_sys);
        ev_seq[0] = event_o;
        drive_key(1'b0, 1'b1, 8'h45);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk_sys);
            ev_seq[i] = event_o;
        end
        check_val("b2b_evt", {28'd0, ev_seq}, 32'h0000_0006);
        check_val("b2b_joy", joystick_o, 32'h0000_0300);

        clear_i = 1'b1;
        @(negedge clk_sys);
        clear_i = 1'b0;
        @(negedge clk_sys);
        check_val("clear_b2b", joystick_o, 32'h0);

        // Clear coinciding with the stage-2 event: event dropped
        drive_key(1'b0, 1'b1, 8'h1D);
        @(negedge clk_sys);
        ev_seq[0] = event_o;
        clear_i = 1'b1;
        @(negedge clk_sys);
        ev_seq[1] = event_o;
        clear_i = 1'b0;
        for (int i = 2; i < 4; i++) begin
            @(negedge clk_sys);
            ev_seq[i] = event_o;
        end
        check_val("clr_vs_evt_evt", {28'd0, ev_seq}, 32'h0);
        check_val("clr_vs_evt_joy", joystick_o, 32'h0);

        // Native joystick merge and idempotent presses/releases
        joy_i = 32'h10;
        @(negedge clk_sys);
        check_val("joy_latency", joystick_o, 32'h0000_0010);
        send_key("dig5",        1'b0, 1'b1, 8'h2E, 1'b1, 32'h0000_2010);
        send_key("dig5_again",  1'b0, 1'b1, 8'h2E, 1'b0, 32'h0000_2010);
        send_key("rel_unheld",  1'b0, 1'b0, 8'h1D, 1'b0, 32'h0000_2010);
        joy_i = 32'h11;
        @(negedge clk_sys);
        check_val("joy_change", joystick_o, 32'h0000_2011);

        // Reset mid-event: state clears immediately and the in-flight event is lost
        joy_i = 32'h0;
        drive_key(1'b0, 1'b1, 8'h36);
        @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        check_val("midrst_joy", joystick_o, 32'h0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        ev_seq = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sys);
            ev_seq[i] = event_o;
        end
        check_val("midrst_evt", {28'd0, ev_seq}, 32'h0);
        check_val("midrst_after", joystick_o, 32'h0);

`ifdef PS2_TURBO_EN
        begin
            logic [11:0] seq;
            drive_key(1'b0, 1'b1, 8'h11);
            idle(2);
            for (int i = 0; i < 12; i++) begin
                @(negedge clk_sys);
                seq[11-i] = joystick_o[5];
            end
            check_val("turbo_seq", {20'd0, seq}, 32'h0000_00F0);
            drive_key(1'b0, 1'b0, 8'h11);
            idle(3);
            check_val("turbo_release", joystick_o, 32'h0);
            drive_key(1'b0, 1'b1, 8'h11);
            idle(2);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk_sys);
                seq[11-i] = joystick_o[5];
            end
            check_val("turbo_restart", {24'd0, seq[11:4]}, 32'h0000_000F);
        end
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
